aes128_iter_core: RTL
=====================

// Module: aes128_iter_core
// PURPOSE
//  Sequential AES-128 core for encryption and decryption, with a valid/ready handshake on
//  input and output. One block is in flight at a time. A parameter sets how many rounds are
//  evaluated per clock, so one module covers the low-area to high-throughput range.
//  It reuses the sub_byte, shift_row, mix_col and round_key11 primitives, plus their inverse
//  counterparts. It sits between the block-mode controller and the data bus.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1  rounds evaluated per clock; legal values are 1, 2, 5 and 10 (must divide 10)
//  NCYC              10/ROUNDS_PER_CYCLE  derived localparam; compute cycles per block
// PORTS
//  clk         in   1      system clock; everything is sampled on the rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      in_data, in_key and in_decrypt are valid
//  in_ready    out  1      core can accept a block
//  in_decrypt  in   1      0 = encrypt, 1 = decrypt (FIPS-197 inverse cipher)
//  in_data     in   [0:127] plaintext or ciphertext; byte 0 is bits [0:7]
//  in_key      in   [0:127] cipher key, same byte order as in_data
//  out_valid   out  1      out_data holds a finished result
//  out_ready   in   1      downstream accepts out_data
//  out_data    out  [0:127] ciphertext or plaintext
//  busy        out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (asynchronous, any cycle, including mid-block): FSM=IDLE, round counter=0, state and
//    out_data registers=0, out_valid=0, busy=0, in_ready=1 (in_ready is combinational from IDLE).
//    Any in-flight block is discarded and no output is produced for it.
//  - FSM states and transitions:
//    IDLE -> RUN on in_valid && in_ready; in_ready = (FSM==IDLE).
//    RUN -> DONE on the edge where counter == NCYC-1.
//    DONE -> IDLE on out_ready && out_valid.
//  - Accept edge:
//    - Latch k0..k10 from the combinational expansion of in_key; latch the mode bit.
//    - Encrypt: state <= in_data ^ k0.
//    - Decrypt: state <= in_data ^ k10.
//    - counter <= 0.
//  - Each RUN edge applies ROUNDS_PER_CYCLE chained rounds to state, then counter++.
//    - Encrypt round r (r = 1..10): SubBytes, ShiftRows, MixColumns (skipped at r=10), XOR k_r.
//    - Decrypt round r (r = 1..10): InvShiftRows, InvSubBytes, XOR k_(10-r), InvMixColumns
//      (skipped at r=10).
//    - Round index = counter*ROUNDS_PER_CYCLE + stage + 1; round keys come from a mux on it.
//  - Latency: out_valid rises NCYC cycles after the accept edge. For RPC=1 that is 10, for
//    RPC=10 it is 1.
//  - Throughput: one block per NCYC+2 cycles. The DONE->IDLE edge is a deliberate bubble.
//  - Output: out_data is loaded on the RUN->DONE edge and held stable while out_valid=1 and
//    out_ready=0. out_valid drops on the edge after the handshake.
//  - in_* inputs are ignored outside IDLE. Changing in_key mid-block has no effect, because the
//    keys were latched at accept.
//  - in_valid and out_ready can never both take effect in one cycle (IDLE and DONE are
//    exclusive), so no simultaneous-event conflict exists.
//  - An illegal ROUNDS_PER_CYCLE stops elaboration via a generate-time $error.
// TESTING
//  1. Encrypt, RPC=1:
//     key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff
//     -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid 10 cycles after accept.
//  2. Decrypt, RPC=1: same key, ct=69c4e0d86a7b0430d8cdb78070b4c55a
//     -> out_data=00112233445566778899aabbccddeeff.
//  3. Encrypt, RPC=2, 5 and 10:
//     key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734
//     -> 3925841d02dc09fbdc118597196a0b32, with latency 5, 2 and 1 respectively.
//  4. Backpressure: hold out_ready=0 for 20 cycles after out_valid
//     -> out_data stable, in_ready=0 throughout; accept the next block only after out_ready=1.
//  5. Reset mid-block: assert rst 4 cycles after accept
//     -> out_valid=0 and in_ready=1 immediately; the next block (test 1 vector) still gives
//        the correct result.
//  6. Back-to-back random blocks, mixed modes, in_valid held high, in_key changed during RUN
//     -> every result matches the C reference model; gap between accepts = NCYC+2 cycles.

Source files
------------

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encrypt/decrypt core with valid/ready
// handshakes. One block in flight; ROUNDS_PER_CYCLE rounds are chained per clock.
// Byte 0 of every 128-bit value is bits [0:7]; bytes fill the state column-major.
module aes128_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_decrypt,
  input  logic [0:127] in_data,
  input  logic [0:127] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  localparam int NCYC = 10 / ROUNDS_PER_CYCLE;

  generate
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
      $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end
  endgenerate

  typedef logic [0:127] blk_t;
  typedef logic [0:10][0:127] ksch_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic and the byte substitution primitives
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // ---------------------------------------------------------------------------
  // Round transformations on a whole 16-byte state
  // ---------------------------------------------------------------------------
  function automatic blk_t sub_bytes(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic blk_t inv_sub_bytes(input blk_t s);
    blk_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row w of the state rotates left by w columns.
  function automatic blk_t shift_rows(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[8*(4*c + w) +: 8] = s[8*(4*((c + w) % 4) + w) +: 8];
    return r;
  endfunction

  function automatic blk_t inv_shift_rows(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[8*(4*c + w) +: 8] = s[8*(4*((c + 4 - w) % 4) + w) +: 8];
    return r;
  endfunction

  function automatic blk_t mix_cols(input blk_t s);
    blk_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic blk_t inv_mix_cols(input blk_t s);
    blk_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      r[32*c      +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[32*c + 8  +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[32*c + 16 +: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[32*c + 24 +: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

  function automatic blk_t enc_round(input blk_t s, input blk_t rk, input logic last);
    blk_t t;
    t = shift_rows(sub_bytes(s));
    if (!last) t = mix_cols(t);
    return t ^ rk;
  endfunction

  function automatic blk_t dec_round(input blk_t s, input blk_t rk, input logic last);
    blk_t t;
    t = inv_sub_bytes(inv_shift_rows(s)) ^ rk;
    if (!last) t = inv_mix_cols(t);
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Key schedule: all eleven round keys from the cipher key in one pass
  // ---------------------------------------------------------------------------
  function automatic logic [0:31] sub_word(input logic [0:31] w);
    logic [0:31] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox(w[8*j +: 8]);
    return r;
  endfunction

  function automatic ksch_t expand_key(input blk_t key);
    logic [0:31] w [44];
    logic [0:31] t;
    logic [7:0]  rc;
    ksch_t       ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[8:31], t[0:7]});
        t[0:7] = t[0:7] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // Chain of ROUNDS_PER_CYCLE rounds; the round index picks the key and
  // decides whether the (inverse) MixColumns step is dropped.
  function automatic blk_t run_rounds(input blk_t s, input ksch_t rk,
                                      input logic dec, input logic [3:0] cnt);
    blk_t       t;
    logic [3:0] r;
    t = s;
    for (int st = 0; st < ROUNDS_PER_CYCLE; st++) begin
      r = 4'(int'(cnt) * ROUNDS_PER_CYCLE + st + 1);
      if (dec) t = dec_round(t, rk[4'd10 - r], r == 4'd10);
      else     t = enc_round(t, rk[r], r == 4'd10);
    end
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Control and datapath
  // ---------------------------------------------------------------------------
  fsm_t       fsm_q, fsm_d;
  blk_t       blk_q, out_q, round_out;
  ksch_t      rk_q, key_exp;
  logic       mode_q;
  logic [3:0] cnt_q;
  logic       accept, finish;

  assign key_exp   = expand_key(in_key);
  assign round_out = run_rounds(blk_q, rk_q, mode_q, cnt_q);
  assign out_data  = out_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    finish    = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          fsm_d  = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt_q == 4'(NCYC - 1)) begin
          finish = 1'b1;
          fsm_d  = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Round keys are captured at accept so later in_key changes cannot leak in
  always_ff @(posedge clk) begin
    if (accept) rk_q <= key_exp;
  end

  // Cipher state, round counter, mode bit and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q  <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      // --- stage boundary: initial AddRoundKey (k0 forward, k10 inverse) ---
      blk_q  <= in_data ^ (in_decrypt ? key_exp[10] : key_exp[0]);
      cnt_q  <= '0;
      mode_q <= in_decrypt;
    end else if (fsm_q == S_RUN) begin
      // --- stage boundary: ROUNDS_PER_CYCLE rounds folded into blk_q ---
      blk_q <= round_out;
      cnt_q <= cnt_q + 4'd1;
      if (finish) out_q <= round_out;
    end
  end

endmodule
